// File: rtl/pt2262_tx_sequencer.sv
// PT2262 transmit sequencer: loads a 12-trit code into the external
// shift register, pulls trits out two bits at a time and encodes them.
module pt2262_tx_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int FRAMES   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [23:0] i_code,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_dout,
    output logic        o_sr_enable,
    output logic [2:0]  o_sr_op,
    output logic [25:0] o_sr_d,
    output logic [1:0]  o_sr_pt2272_bit,
    input  logic [1:0]  i_sr_q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_TRIT = 2'd2;
    localparam logic [1:0] S_SYNC = 2'd3;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_SHL2 = 3'b100;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(FRAMES - 1);

    logic [1:0]    r_state;
    logic [TW-1:0] r_tick;
    logic [4:0]    r_unit;
    logic [3:0]    r_trit;
    logic [FW-1:0] r_frame;
    logic [1:0]    r_cur;

    logic [1:0]    w_state;
    logic [TW-1:0] w_tick;
    logic [4:0]    w_unit;
    logic [3:0]    w_trit;
    logic [FW-1:0] w_frame;
    logic [1:0]    w_cur;
    logic          w_tick_end;
    logic          w_accept;
    logic          w_done;
    logic          w_issue_shift;
    logic          w_issue_load;
    logic          w_long;
    logic          w_dout;

    assign o_sr_pt2272_bit = 2'b00;

    always_comb begin
        w_state       = r_state;
        w_tick        = r_tick;
        w_unit        = r_unit;
        w_trit        = r_trit;
        w_frame       = r_frame;
        w_cur         = r_cur;
        w_accept      = 1'b0;
        w_done        = 1'b0;
        w_issue_shift = 1'b0;
        w_issue_load  = 1'b0;
        w_tick_end    = (r_tick == TICK_MAX);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state  = S_LOAD;
                    w_tick   = '0;
                    w_unit   = '0;
                    w_trit   = '0;
                    w_frame  = '0;
                    w_accept = 1'b1;
                end
            end
            S_LOAD: begin
                if (r_unit == 5'd2) begin
                    w_state = S_TRIT;
                    w_unit  = '0;
                end else begin
                    w_unit = r_unit + 5'd1;
                end
            end
            S_TRIT: begin
                // head trit is captured and the next one shifted in
                if (r_unit[2:0] == 3'd0 && r_tick == '0) begin
                    w_cur         = i_sr_q;
                    w_issue_shift = 1'b1;
                end
                if (w_tick_end) begin
                    w_tick = '0;
                    if (r_unit[2:0] == 3'd7) begin
                        w_unit = '0;
                        if (r_trit == 4'd11) begin
                            w_state = S_SYNC;
                        end else begin
                            w_trit = r_trit + 4'd1;
                        end
                    end else begin
                        w_unit = r_unit + 5'd1;
                    end
                end else begin
                    w_tick = r_tick + 1'b1;
                end
            end
            default: begin
                if (r_unit == 5'd0 && r_tick == '0) begin
                    w_issue_load = 1'b1;
                end
                if (w_tick_end) begin
                    w_tick = '0;
                    if (r_unit == 5'd31) begin
                        w_unit = '0;
                        w_trit = '0;
                        if (r_frame == FRAME_MAX) begin
                            w_state = S_IDLE;
                            w_done  = 1'b1;
                        end else begin
                            w_state = S_TRIT;
                            w_frame = r_frame + 1'b1;
                        end
                    end else begin
                        w_unit = r_unit + 5'd1;
                    end
                end else begin
                    w_tick = r_tick + 1'b1;
                end
            end
        endcase
    end

    // waveform level for the upcoming cycle, so o_dout is a plain flop
    always_comb begin
        w_long = w_unit[2] ? (w_cur != 2'b00) : (w_cur == 2'b11);
        w_dout = 1'b0;
        if (w_state == S_TRIT) begin
            w_dout = (w_unit[1:0] == 2'b00) ||
                     (w_long && w_unit[1:0] != 2'b11);
        end else if (w_state == S_SYNC) begin
            w_dout = (w_unit == 5'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_unit      <= '0;
            r_trit      <= '0;
            r_frame     <= '0;
            r_cur       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_dout      <= 1'b0;
            o_sr_enable <= 1'b0;
            o_sr_op     <= OP_HOLD;
            o_sr_d      <= '0;
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_unit  <= w_unit;
            r_trit  <= w_trit;
            r_frame <= w_frame;
            r_cur   <= w_cur;
            o_done  <= w_done;
            o_dout  <= w_dout;
            if (w_accept) begin
                o_busy <= 1'b1;
                o_sr_d <= {i_code, 2'b00};
            end else if (w_done) begin
                o_busy <= 1'b0;
            end
            if (w_accept || w_issue_load) begin
                o_sr_op     <= OP_LOAD;
                o_sr_enable <= 1'b0;
            end else if (w_issue_shift) begin
                o_sr_op     <= OP_SHL2;
                o_sr_enable <= 1'b0;
            end else if (o_sr_enable) begin
                o_sr_op     <= OP_HOLD;
                o_sr_enable <= 1'b0;
            end else if (o_sr_op != OP_HOLD) begin
                o_sr_enable <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pt2262_tx_sequencer.sv
// Bench for pt2262_tx_sequencer: two instances (TICK_DIV/FRAMES 1/1 and
// 4/3), each with a behavioural 26-bit shift register on its strobe port.
module tb_pt2262_tx_sequencer;

    typedef logic [2:0] obs_t;

    logic                  clk;
    logic [1:0]            rst_n;
    logic [1:0]            start;
    logic [1:0][23:0]      code;
    logic [1:0]            busy;
    logic [1:0]            done;
    logic [1:0]            dout;
    logic [1:0]            sr_en;
    logic [1:0][2:0]       sr_op;
    logic [1:0][25:0]      sr_d;
    logic [1:0][1:0]       sr_fill;
    logic [1:0][1:0]       sr_q;
    logic [1:0][31:0]      nload;
    logic [1:0][31:0]      nshift;
    logic [1:0][31:0]      nerr;

    obs_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int GTD = (g == 0) ? 1 : 4;
        localparam int GFR = (g == 0) ? 1 : 3;
        logic [25:0] q = '0;
        int          n_load = 0;
        int          n_shift = 0;
        int          n_err = 0;
        logic        pen = 1'b0;
        logic [2:0]  pop = '0;
        logic [25:0] pd = '0;

        pt2262_tx_sequencer #(.TICK_DIV(GTD), .FRAMES(GFR)) u_dut (
            .i_clk          (clk),
            .i_rst_n        (rst_n[g]),
            .i_start        (start[g]),
            .i_code         (code[g]),
            .o_busy         (busy[g]),
            .o_done         (done[g]),
            .o_dout         (dout[g]),
            .o_sr_enable    (sr_en[g]),
            .o_sr_op        (sr_op[g]),
            .o_sr_d         (sr_d[g]),
            .o_sr_pt2272_bit(sr_fill[g]),
            .i_sr_q         (sr_q[g])
        );

        always @(posedge clk) begin
            if (sr_en[g]) begin
                if (sr_op[g] == 3'b011) q <= sr_d[g];
                else if (sr_op[g] == 3'b100) q <= {q[23:0], sr_fill[g]};
            end
        end
        assign sr_q[g] = q[25:24];

        // strobe protocol watcher
        always @(negedge clk) begin
            if (sr_en[g]) begin
                if (pen || sr_op[g] == 3'b000 || sr_op[g] != pop ||
                    sr_d[g] != pd) n_err = n_err + 1;
                if (sr_op[g] == 3'b011) n_load = n_load + 1;
                if (sr_op[g] == 3'b100) n_shift = n_shift + 1;
            end
            if (pen && sr_op[g] != 3'b000) n_err = n_err + 1;
            if (sr_fill[g] != 2'b00) n_err = n_err + 1;
            pen = sr_en[g];
            pop = sr_op[g];
            pd  = sr_d[g];
        end
        assign nload[g]  = n_load;
        assign nshift[g] = n_shift;
        assign nerr[g]   = n_err;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_frames(input logic [23:0] c, input int td,
                               input int fr);
        logic [1:0] tr;
        logic [1:0] pl;
        logic       hi;
        repeat (3) sb.push_back(3'b100);
        for (int f = 0; f < fr; f++) begin
            for (int t = 0; t < 12; t++) begin
                tr = c[23-2*t -: 2];
                case (tr)
                    2'b00:   pl = 2'b00;
                    2'b11:   pl = 2'b11;
                    default: pl = 2'b01;
                endcase
                for (int p = 0; p < 2; p++) begin
                    for (int u = 0; u < 4; u++) begin
                        hi = (u == 0) || (u < 3 && pl[1-p]);
                        repeat (td) sb.push_back({2'b10, hi});
                    end
                end
            end
            for (int u = 0; u < 32; u++) begin
                repeat (td) sb.push_back({2'b10, u == 0});
            end
        end
        sb.push_back(3'b010);
        sb.push_back(3'b000);
    endtask

    function automatic logic [34:0] out_vec(input int idx);
        return {busy[idx], done[idx], dout[idx], sr_en[idx],
                sr_op[idx], sr_d[idx], sr_fill[idx]};
    endfunction

    task automatic run(input int idx, input logic [23:0] c, input int td,
                       input int fr, input int rst_at, input int spur_at);
        int   cyc;
        int   l0;
        int   s0;
        obs_t o;
        obs_t e;
        l0 = nload[idx];
        s0 = nshift[idx];
        push_frames(c, td, fr);
        @(posedge clk);
        #1;
        code[idx]  = c;
        start[idx] = 1'b1;
        @(posedge clk);
        #1;
        start[idx] = 1'b0;
        code[idx]  = ~c;
        cyc = 1;
        while (sb.size() > 0) begin
            @(negedge clk);
            o = {busy[idx], done[idx], dout[idx]};
            e = sb.pop_front();
            chk($sformatf("i%0d code=%h cyc%0d bdo", idx, c, cyc), o, e);
            if (cyc == 2) begin
                chk("load strobe", {sr_en[idx], sr_op[idx], sr_d[idx]},
                    {1'b1, 3'b011, c, 2'b00});
            end
            start[idx] = (cyc == spur_at);
            if (cyc == spur_at) code[idx] = 24'h123456;
            if (cyc == rst_at) begin
                @(posedge clk);
                #1;
                rst_n[idx] = 1'b0;
                #1;
                chk("async reset", out_vec(idx), '0);
                sb.delete();
                @(negedge clk);
                rst_n[idx] = 1'b1;
                break;
            end
            cyc++;
        end
        start[idx] = 1'b0;
        if (rst_at < 0) begin
            chk("load count", nload[idx] - l0, fr + 1);
            chk("shift count", nshift[idx] - s0, 12 * fr);
        end
        chk("strobe protocol", nerr[idx], 0);
    endtask

    initial begin
        rst_n = 2'b00;
        start = 2'b00;
        code  = '0;
        #12;
        chk("reset i0", out_vec(0), '0);
        chk("reset i1", out_vec(1), '0);
        @(negedge clk);
        rst_n = 2'b11;
        run(0, 24'h000000, 1, 1, -1, -1);
        run(0, 24'hFFFFFF, 1, 1, -1, -1);
        run(0, 24'h555555, 1, 1, -1, -1);
        run(0, 24'hAAAAAA, 1, 1, -1, -1);
        run(1, 24'h5A3C96, 4, 3, -1, 700);
        run(0, 24'h6D2B81, 1, 1, 46, -1);
        run(0, 24'h6D2B81, 1, 1, -1, -1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
